// File: rtl/risc23_pkg.sv
// Shared types and sizes for the risc23 pipeline: register file geometry,
// operand-select encodings and the register-read stage state type.
package risc23_pkg;

  localparam int XLEN = 16;
  localparam int NREG = 8;
  localparam int AW   = $clog2(NREG);

  typedef enum logic [1:0] {
    SRC_RA  = 2'd0,
    SRC_RB  = 2'd1,
    SRC_IMM = 2'd2,
    SRC_PC  = 2'd3
  } src_sel_e;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_regs.sv
// NREG x XLEN architectural register file: one write port, three combinational
// read ports. Define RF_BYPASS_EN to make a same-cycle write visible on reads.
module rf_regs
  import risc23_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  input  logic [AW-1:0]   raddr_c,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b,
  output logic [XLEN-1:0] rdata_c
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  // With bypass, a read of the register being written sees the new data now.
  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
`ifdef RF_BYPASS_EN
    if (we && (waddr == addr)) return wdata;
`endif
    return regs_q[addr];
  endfunction

  assign rdata_a = read_port(raddr_a);
  assign rdata_b = read_port(raddr_b);
  assign rdata_c = read_port(raddr_c);

endmodule

// File: rtl/rf_read_stage.sv
// Register-read stage: register file, load-use hazard detection, stall FSM and
// saturating stall counter. RF_BYPASS_EN selects write-through reads.
module rf_read_stage
  import risc23_pkg::*;
#(
  parameter int LDUSE_STALL = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rc,
  input  logic [1:0]       srcA_sel,
  input  logic [1:0]       srcB_sel,
  input  logic             mem_wr,
  input  logic             ex_mem_rd,
  input  logic             ex_rf_we,
  input  logic [AW-1:0]    ex_waddr,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  rd_a,
  output logic [XLEN-1:0]  rd_b,
  output logic [XLEN-1:0]  rd_c,
  output logic             stall,
  output logic             bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  rf_state_e        state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             use_a, use_b, ld_hz, wb_hz;

  rf_regs u_regs (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (ra),
    .raddr_b (rb),
    .raddr_c (rc),
    .rdata_a (rd_a),
    .rdata_b (rd_b),
    .rdata_c (rd_c)
  );

  assign use_a = (srcA_sel == SRC_RA) || mem_wr;
  assign use_b = (srcB_sel == SRC_RB);
  assign ld_hz = ex_mem_rd && ex_rf_we &&
                 ((use_a && (ex_waddr == ra)) || (use_b && (ex_waddr == rb)));

  // Without bypass, reading a register in the cycle it is written costs one stall.
`ifdef RF_BYPASS_EN
  assign wb_hz = 1'b0;
`else
  assign wb_hz = wb_we && ((use_a && (wb_addr == ra)) || (use_b && (wb_addr == rb)));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    if (rst) begin
      state_d = S_RUN;
      cnt_d   = '0;
    end else if (flush) begin
      state_d = S_RUN;
      cnt_d   = '0;
      bubble  = 1'b1;
    end else if (state_q == S_STALL) begin
      stall  = 1'b1;
      bubble = 1'b1;
      if (cnt_q == 3'd1) begin
        state_d = S_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end else if (ld_hz) begin
      stall  = 1'b1;
      bubble = 1'b1;
      if (LDUSE_STALL > 1) begin
        state_d = S_STALL;
        cnt_d   = 3'(LDUSE_STALL - 1);
      end
    end else if (wb_hz) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rf_read_stage.sv
// Scoreboard bench for rf_read_stage: two instances (LDUSE_STALL=1/CNT_W=16 and
// LDUSE_STALL=3/CNT_W=4) share stimulus and are checked against a reference model.
module tb_rf_read_stage;
  import risc23_pkg::*;

  typedef struct {
    bit          rst;
    bit          flush;
    logic [2:0]  ra, rb, rc;
    logic [1:0]  srca, srcb;
    bit          mem_wr, ex_mem_rd, ex_rf_we;
    logic [2:0]  ex_waddr;
    bit          wb_we;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
  } cyc_t;

  typedef struct {
    bit          full;
    logic [15:0] ra, rb, rc;
    bit          st_a, bu_a, st_b, bu_b;
    int          sc_a, sc_b;
  } exp_t;

  logic        clk;
  logic        rst, flush, mem_wr, ex_mem_rd, ex_rf_we, wb_we;
  logic [2:0]  ra, rb, rc, ex_waddr, wb_addr;
  logic [1:0]  srca_sel, srcb_sel;
  logic [15:0] wb_data;
  logic [15:0] rd_a_a, rd_b_a, rd_c_a, rd_a_b, rd_b_b, rd_c_b;
  logic        stall_a, bubble_a, stall_b, bubble_b;
  logic [15:0] stall_cnt_a;
  logic [3:0]  stall_cnt_b;

  exp_t        sb[$];
  logic [15:0] mem [8];
  int          rem_a, rem_b, sc_a, sc_b;
  bit          known;
  int          n_cmp, n_bad;

  rf_read_stage #(.LDUSE_STALL(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .ra(ra), .rb(rb), .rc(rc),
    .srcA_sel(srca_sel), .srcB_sel(srcb_sel), .mem_wr(mem_wr),
    .ex_mem_rd(ex_mem_rd), .ex_rf_we(ex_rf_we), .ex_waddr(ex_waddr),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_a(rd_a_a), .rd_b(rd_b_a), .rd_c(rd_c_a),
    .stall(stall_a), .bubble(bubble_a), .stall_cnt(stall_cnt_a)
  );

  rf_read_stage #(.LDUSE_STALL(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .ra(ra), .rb(rb), .rc(rc),
    .srcA_sel(srca_sel), .srcB_sel(srcb_sel), .mem_wr(mem_wr),
    .ex_mem_rd(ex_mem_rd), .ex_rf_we(ex_rf_we), .ex_waddr(ex_waddr),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_a(rd_a_b), .rd_b(rd_b_b), .rd_c(rd_c_b),
    .stall(stall_b), .bubble(bubble_b), .stall_cnt(stall_cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic cyc_t idle();
    cyc_t c;
    c.rst = 0; c.flush = 0; c.ra = 0; c.rb = 0; c.rc = 0;
    c.srca = SRC_IMM; c.srcb = SRC_IMM; c.mem_wr = 0;
    c.ex_mem_rd = 0; c.ex_rf_we = 0; c.ex_waddr = 0;
    c.wb_we = 0; c.wb_addr = 0; c.wb_data = 0;
    return c;
  endfunction

  function automatic cyc_t load_use();
    cyc_t c = idle();
    c.ra = 3'd2; c.srca = SRC_RA;
    c.ex_mem_rd = 1; c.ex_rf_we = 1; c.ex_waddr = 3'd2;
    return c;
  endfunction

  // Stall behaviour as a count of remaining stall cycles rather than FSM states.
  task automatic model_step(input cyc_t c, input bit ldhz, input bit wbhz,
                            input int len, input int sat,
                            inout int rem, inout int sc,
                            output bit st, output bit bu, output int sc_o);
    st = 0; bu = 0; sc_o = sc;
    if (c.rst) begin
    end else if (c.flush) begin
      rem = 0; bu = 1;
    end else if (rem > 0) begin
      st = 1; bu = 1; rem--;
    end else if (ldhz) begin
      st = 1; bu = 1; rem = len - 1;
    end else if (wbhz) begin
      st = 1; bu = 1;
    end
    if (st && sc < sat) sc++;
  endtask

  function automatic logic [15:0] model_read(input cyc_t c, input logic [2:0] a);
`ifdef RF_BYPASS_EN
    if (c.wb_we && c.wb_addr == a) return c.wb_data;
`endif
    return mem[a];
  endfunction

  task automatic apply_stimulus(input cyc_t c);
    exp_t e;
    bit use_a, use_b, ldhz, wbhz;
    rst = c.rst; flush = c.flush; ra = c.ra; rb = c.rb; rc = c.rc;
    srca_sel = c.srca; srcb_sel = c.srcb; mem_wr = c.mem_wr;
    ex_mem_rd = c.ex_mem_rd; ex_rf_we = c.ex_rf_we; ex_waddr = c.ex_waddr;
    wb_we = c.wb_we; wb_addr = c.wb_addr; wb_data = c.wb_data;

    e.full = known;
    e.ra = model_read(c, c.ra);
    e.rb = model_read(c, c.rb);
    e.rc = model_read(c, c.rc);
    use_a = (c.srca == SRC_RA) || c.mem_wr;
    use_b = (c.srcb == SRC_RB);
    ldhz = c.ex_mem_rd && c.ex_rf_we &&
           ((use_a && c.ex_waddr == c.ra) || (use_b && c.ex_waddr == c.rb));
`ifdef RF_BYPASS_EN
    wbhz = 0;
`else
    wbhz = c.wb_we && ((use_a && c.wb_addr == c.ra) || (use_b && c.wb_addr == c.rb));
`endif
    model_step(c, ldhz, wbhz, 1, 65535, rem_a, sc_a, e.st_a, e.bu_a, e.sc_a);
    model_step(c, ldhz, wbhz, 3, 15, rem_b, sc_b, e.st_b, e.bu_b, e.sc_b);

    if (c.rst) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'h0;
      rem_a = 0; rem_b = 0; sc_a = 0; sc_b = 0;
      known = 1;
    end else if (c.wb_we) begin
      mem[c.wb_addr] = c.wb_data;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_output("stall_a", 32'(stall_a), 32'(e.st_a));
      check_output("bubble_a", 32'(bubble_a), 32'(e.bu_a));
      check_output("stall_b", 32'(stall_b), 32'(e.st_b));
      check_output("bubble_b", 32'(bubble_b), 32'(e.bu_b));
      if (e.full) begin
        check_output("rd_a", 32'(rd_a_a), 32'(e.ra));
        check_output("rd_b", 32'(rd_b_a), 32'(e.rb));
        check_output("rd_c", 32'(rd_c_a), 32'(e.rc));
        check_output("rd_a_b", 32'(rd_a_b), 32'(e.ra));
        check_output("rd_b_b", 32'(rd_b_b), 32'(e.rb));
        check_output("rd_c_b", 32'(rd_c_b), 32'(e.rc));
        check_output("stall_cnt_a", 32'(stall_cnt_a), 32'(e.sc_a));
        check_output("stall_cnt_b", 32'(stall_cnt_b), 32'(e.sc_b));
      end
    end
  end

  initial begin
    cyc_t c;
    n_cmp = 0; n_bad = 0; known = 0;
    rem_a = 0; rem_b = 0; sc_a = 0; sc_b = 0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    c = idle(); c.rst = 1;
    rst = 1; flush = 0; ra = 0; rb = 0; rc = 0; srca_sel = SRC_IMM; srcb_sel = SRC_IMM;
    mem_wr = 0; ex_mem_rd = 0; ex_rf_we = 0; ex_waddr = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    @(posedge clk);
    #1;

    apply_stimulus(c);
    apply_stimulus(c);

    c = idle(); c.wb_we = 1; c.wb_addr = 3'd3; c.wb_data = 16'hBEEF;
    apply_stimulus(c);
    c = idle(); c.ra = 3'd3; c.srca = SRC_RA;
    apply_stimulus(c);

    // Load-use: EX holds the load for one cycle, then a bubble follows it.
    c = load_use();
    apply_stimulus(c);
    c.ex_mem_rd = 0;
    repeat (3) apply_stimulus(c);

    c = idle(); c.rb = 3'd5; c.srcb = SRC_RB;
    c.wb_we = 1; c.wb_addr = 3'd5; c.wb_data = 16'h1234;
    apply_stimulus(c);
    c.wb_we = 0;
    repeat (2) apply_stimulus(c);

    c = load_use();
    apply_stimulus(c);
    c = idle(); c.flush = 1;
    apply_stimulus(c);
    c.flush = 0;
    repeat (2) apply_stimulus(c);

    c = load_use();
    apply_stimulus(c);
    c = idle(); c.rst = 1;
    apply_stimulus(c);
    c = idle(); c.ra = 3'd3; c.rb = 3'd5; c.rc = 3'd2;
    apply_stimulus(c);

    c = load_use();
    repeat (20) apply_stimulus(c);
    apply_stimulus(idle());

    for (int n = 0; n < 400; n++) begin
      c.rst       = ($urandom_range(0, 49) == 0);
      c.flush     = ($urandom_range(0, 7) == 0);
      c.ra        = 3'($urandom_range(0, 7));
      c.rb        = 3'($urandom_range(0, 7));
      c.rc        = 3'($urandom_range(0, 7));
      c.srca      = 2'($urandom_range(0, 3));
      c.srcb      = 2'($urandom_range(0, 3));
      c.mem_wr    = ($urandom_range(0, 3) == 0);
      c.ex_mem_rd = ($urandom_range(0, 1) == 1);
      c.ex_rf_we  = ($urandom_range(0, 3) != 0);
      c.ex_waddr  = 3'($urandom_range(0, 7));
      c.wb_we     = ($urandom_range(0, 1) == 1);
      c.wb_addr   = 3'($urandom_range(0, 7));
      c.wb_data   = 16'($urandom);
      apply_stimulus(c);
    end
    apply_stimulus(idle());

    @(negedge clk);
    #1;
    check_output("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
